pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the fixed per-stage registers (F/D, D/E, E/M, M/W) with one block instantiated once per boundary. It carries IR, PC and N_DATA 32-bit payload words plus a valid bit, and derives PC+4/PC+8. It supports hold, flush and bubble insertion with a fixed priority. It keeps saturating hold, bubble and flush counters for hazard-unit debug and performance monitoring.

## Interface
- N_DATA, 3, number of 32-bit payload words (D/E: RD1, RD2, EXT)
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high; clock clk
- stall_i  in  1  downstream hold: keep current contents
- flush_i  in  1  kill contents (branch/exception)
- bubble_i  in  1  upstream stalled: insert NOP, keep PC
- valid_i  in  1  incoming instruction is real
- ir_i  in  32  incoming instruction word
- pc_i  in  32  incoming PC
- data_i  in  32*N_DATA  payload; word k at bits [32k+31:32k]
- valid_o  out  1  registered valid
- ir_o  out  32  registered IR
- pc_o  out  32  registered PC
- pc4_o  out  32  pc_o + 4, combinational from pc_o
- pc8_o  out  32  pc_o + 8, combinational from pc_o
- data_o  out  32*N_DATA  registered payload
- hold_cnt_o  out  CNT_W  saturating count of cycles spent in hold while valid_o=1
- bubble_cnt_o  out  CNT_W  saturating count of bubbles inserted
- flush_cnt_o  out  CNT_W  saturating count of flushes applied

## Operation
- Per-cycle action, strict priority: reset > flush > stall > bubble > load.
- reset: ir_o=0, pc_o=RESET_PC, data_o=0, valid_o=0, all counters=0.
- flush: ir_o=0 (NOP), data_o=0, valid_o=0, pc_o<=pc_i. Flush overrides stall.
- stall (no flush): all payload registers and valid_o hold their values. If valid_o=1, hold_cnt increments.
- bubble (no flush, no stall): ir_o=0, data_o=0, valid_o=0, pc_o<=pc_i. The PC is kept so exception EPC reporting stays correct. bubble_cnt increments.
- load (no control active): ir_o<=ir_i, pc_o<=pc_i, data_o<=data_i, valid_o<=valid_i.
- A flush increments flush_cnt, including when stall_i or bubble_i is also asserted.
- Counters saturate at all-ones, do not wrap, and clear only on reset.
- pc4_o/pc8_o use modulo-2^32 addition; 32'hFFFF_FFFC gives pc4_o=0 and pc8_o=4.
- A NOP is 32'h0000_0000 (sll $0,$0,0). The stage treats ir as opaque and never decodes it.

## Timing
- One-cycle latency: inputs sampled at posedge N appear on outputs after posedge N.
- No combinational path from any input to any output. pc4_o/pc8_o depend only on pc_o.
- Counter updates land in the same edge as the action that triggers them.
- Reset asserted mid-stall or mid-flush wins that edge. The first post-reset edge performs a normal prioritised action.
- Simultaneous stall_i and bubble_i: stall wins. bubble_cnt is unchanged.
- Holding stall_i for many cycles keeps outputs bit-stable. hold_cnt steps by 1 per edge only while valid_o=1.

## Structure
- Shared package pipe_pkg holds:
  - WORD_W=32
  - NOP_INSTR=32'h0
  - DEFAULT_RESET_PC=32'h0000_3000
  - the stage_action_e enum (ACT_RESET, ACT_FLUSH, ACT_HOLD, ACT_BUBBLE, ACT_LOAD)
- A combinational priority decode produces stage_action_e. One always block per register group switches on it.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc_i, cnt_o), instantiated three times.

## Test plan
- Reset: assert reset for 2 cycles. Expect pc_o=32'h3000, pc4_o=32'h3004, pc8_o=32'h3008, ir_o=0, valid_o=0, all counters 0.
- Load: ir_i=32'h3C01_1234, pc_i=32'h3010, data_i words {5,7,9}, valid_i=1. Next cycle the outputs match exactly and pc8_o=32'h3018.
- Stall: stall_i=1 for 4 cycles while new inputs toggle. Outputs remain unchanged and hold_cnt_o=4.
- Flush beats stall: stall_i=1, flush_i=1, pc_i=32'h3020. Next cycle ir_o=0, valid_o=0, pc_o=32'h3020, flush_cnt_o=1, hold_cnt_o unchanged.
- Bubble: bubble_i=1, pc_i=32'h3024, ir_i=32'h0800_0C00. Next cycle ir_o=0, data_o=0, valid_o=0, pc_o=32'h3024, bubble_cnt_o=1. Same with stall_i=1 also set: hold, bubble_cnt_o unchanged.
- Saturation and wrap: with CNT_W=2, 5 bubbles give bubble_cnt_o=3. With pc_i=32'hFFFF_FFFC, expect pc4_o=0 and pc8_o=4.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: word width,
// NOP encoding, default reset PC and the per-cycle stage action decode.
package pipe_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [2:0] {
        ACT_RESET  = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_HOLD   = 3'd2,
        ACT_BUBBLE = 3'd3,
        ACT_LOAD   = 3'd4
    } stage_action_e;

    // Strict priority: reset > flush > stall > bubble > load.
    function automatic stage_action_e decode_action(
        input logic reset,
        input logic flush,
        input logic stall,
        input logic bubble
    );
        if (reset)       return ACT_RESET;
        else if (flush)  return ACT_FLUSH;
        else if (stall)  return ACT_HOLD;
        else if (bubble) return ACT_BUBBLE;
        else             return ACT_LOAD;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: steps by one on inc_i, sticks at all-ones,
// clears only on synchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (IR, PC, payload, valid) with
// hold/flush/bubble control and saturating hazard statistics counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          N_DATA   = 3,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     bubble_i,
    input  logic                     valid_i,
    input  logic [WORD_W-1:0]        ir_i,
    input  logic [WORD_W-1:0]        pc_i,
    input  logic [WORD_W*N_DATA-1:0] data_i,
    output logic                     valid_o,
    output logic [WORD_W-1:0]        ir_o,
    output logic [WORD_W-1:0]        pc_o,
    output logic [WORD_W-1:0]        pc4_o,
    output logic [WORD_W-1:0]        pc8_o,
    output logic [WORD_W*N_DATA-1:0] data_o,
    output logic [CNT_W-1:0]         hold_cnt_o,
    output logic [CNT_W-1:0]         bubble_cnt_o,
    output logic [CNT_W-1:0]         flush_cnt_o
);

    // Control semantics: no handshake; stall_i/flush_i/bubble_i are level
    // controls sampled every posedge and resolved by decode_action().
    stage_action_e action;

    logic                     valid_q;
    logic [WORD_W-1:0]        ir_q;
    logic [WORD_W-1:0]        pc_q;
    logic [WORD_W*N_DATA-1:0] data_q;

    logic hold_inc;
    logic bubble_inc;
    logic flush_inc;

    always_comb begin
        action = decode_action(reset, flush_i, stall_i, bubble_i);
    end

    // Instruction group: IR, payload and valid move together.
    always_ff @(posedge clk) begin
        case (action)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                valid_q <= 1'b0;
                ir_q    <= NOP_INSTR;
                data_q  <= '0;
            end
            ACT_LOAD: begin
                valid_q <= valid_i;
                ir_q    <= ir_i;
                data_q  <= data_i;
            end
            default: begin
                valid_q <= valid_q;
                ir_q    <= ir_q;
                data_q  <= data_q;
            end
        endcase
    end

    // PC survives flush/bubble so a killed slot still reports a correct EPC.
    always_ff @(posedge clk) begin
        case (action)
            ACT_RESET:                        pc_q <= RESET_PC;
            ACT_FLUSH, ACT_BUBBLE, ACT_LOAD:  pc_q <= pc_i;
            default:                          pc_q <= pc_q;
        endcase
    end

    always_comb begin
        hold_inc   = (action == ACT_HOLD) && valid_q;
        bubble_inc = (action == ACT_BUBBLE);
        flush_inc  = (action == ACT_FLUSH);
    end

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (hold_inc),
        .cnt_o (hold_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

    assign valid_o = valid_q;
    assign ir_o    = ir_q;
    assign pc_o    = pc_q;
    assign data_o  = data_q;
    assign pc4_o   = pc_q + 32'd4;
    assign pc8_o   = pc_q + 32'd8;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a CNT_W=16 instance and a CNT_W=2
// instance share one stimulus stream; the narrow one exercises saturation.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic        bubble_i;
    logic        valid_i;
    logic [31:0] ir_i;
    logic [31:0] pc_i;
    logic [95:0] data_i;

    logic        valid_o,  valid2_o;
    logic [31:0] ir_o,     ir2_o;
    logic [31:0] pc_o,     pc2_o;
    logic [31:0] pc4_o,    pc42_o;
    logic [31:0] pc8_o,    pc82_o;
    logic [95:0] data_o,   data2_o;
    logic [15:0] hold_cnt_o, bubble_cnt_o, flush_cnt_o;
    logic [1:0]  hold2_cnt,  bubble2_cnt,  flush2_cnt;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];

    pipe_stage_reg #(.N_DATA(3), .RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .bubble_i(bubble_i), .valid_i(valid_i), .ir_i(ir_i), .pc_i(pc_i),
        .data_i(data_i), .valid_o(valid_o), .ir_o(ir_o), .pc_o(pc_o),
        .pc4_o(pc4_o), .pc8_o(pc8_o), .data_o(data_o),
        .hold_cnt_o(hold_cnt_o), .bubble_cnt_o(bubble_cnt_o),
        .flush_cnt_o(flush_cnt_o)
    );

    pipe_stage_reg #(.N_DATA(3), .RESET_PC(32'h0000_3000), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .bubble_i(bubble_i), .valid_i(valid_i), .ir_i(ir_i), .pc_i(pc_i),
        .data_i(data_i), .valid_o(valid2_o), .ir_o(ir2_o), .pc_o(pc2_o),
        .pc4_o(pc42_o), .pc8_o(pc82_o), .data_o(data2_o),
        .hold_cnt_o(hold2_cnt), .bubble_cnt_o(bubble2_cnt),
        .flush_cnt_o(flush2_cnt)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic bu,
                         input logic v, input logic [31:0] ir,
                         input logic [31:0] pc, input logic [95:0] d);
        stall_i  = st;
        flush_i  = fl;
        bubble_i = bu;
        valid_i  = v;
        ir_i     = ir;
        pc_i     = pc;
        data_i   = d;
    endtask

    // Scoreboard compare
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 96'h0);

        // Reset for two cycles
        step();
        step();
        chk("rst_pc",     pc_o,  32'h0000_3000);
        chk("rst_pc4",    pc4_o, 32'h0000_3004);
        chk("rst_pc8",    pc8_o, 32'h0000_3008);
        chk("rst_ir",     ir_o,  32'h0);
        chk("rst_valid",  32'(valid_o), 32'd0);
        chk("rst_data0",  data_o[31:0], 32'h0);
        chk("rst_hold",   32'(hold_cnt_o), 32'd0);
        chk("rst_bubble", 32'(bubble_cnt_o), 32'd0);
        chk("rst_flush",  32'(flush_cnt_o), 32'd0);

        // Load
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3C01_1234, 32'h0000_3010,
              {32'd9, 32'd7, 32'd5});
        step();
        chk("ld_ir",    ir_o,  32'h3C01_1234);
        chk("ld_pc",    pc_o,  32'h0000_3010);
        chk("ld_pc4",   pc4_o, 32'h0000_3014);
        chk("ld_pc8",   pc8_o, 32'h0000_3018);
        chk("ld_valid", 32'(valid_o), 32'd1);
        chk("ld_d0",    data_o[31:0],  32'd5);
        chk("ld_d1",    data_o[63:32], 32'd7);
        chk("ld_d2",    data_o[95:64], 32'd9);

        // Stall 4 cycles with toggling inputs; contents must not move
        exp_q.push_back(32'h3C01_1234);
        exp_q.push_back(32'h0000_3010);
        exp_q.push_back(32'd5);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, i[0], $urandom, $urandom,
                  {$urandom, $urandom, $urandom});
            step();
            chk("st_ir", ir_o, exp_q[0]);
            chk("st_pc", pc_o, exp_q[1]);
            chk("st_d0", data_o[31:0], exp_q[2]);
            chk("st_valid", 32'(valid_o), 32'd1);
        end
        exp_q.delete();
        chk("st_hold",     32'(hold_cnt_o), 32'd4);
        chk("st_hold_sat", 32'(hold2_cnt),  32'd3);

        // Flush beats stall
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_3020,
              {32'd1, 32'd2, 32'd3});
        step();
        chk("fl_ir",    ir_o, 32'h0);
        chk("fl_valid", 32'(valid_o), 32'd0);
        chk("fl_pc",    pc_o, 32'h0000_3020);
        chk("fl_d1",    data_o[63:32], 32'h0);
        chk("fl_flush", 32'(flush_cnt_o), 32'd1);
        chk("fl_hold",  32'(hold_cnt_o), 32'd4);

        // Stall on an invalid slot does not count as a hold
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_3ABC,
              {32'd4, 32'd4, 32'd4});
        step();
        chk("sti_hold", 32'(hold_cnt_o), 32'd4);
        chk("sti_pc",   pc_o, 32'h0000_3020);

        // Bubble keeps PC, kills the rest
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0800_0C00, 32'h0000_3024,
              {32'd6, 32'd6, 32'd6});
        step();
        chk("bu_ir",     ir_o, 32'h0);
        chk("bu_d2",     data_o[95:64], 32'h0);
        chk("bu_valid",  32'(valid_o), 32'd0);
        chk("bu_pc",     pc_o, 32'h0000_3024);
        chk("bu_bubble", 32'(bubble_cnt_o), 32'd1);

        // Reload, then stall+bubble: stall wins
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_5555, 32'h0000_3028,
              {32'd12, 32'd11, 32'd10});
        step();
        chk("ld2_ir", ir_o, 32'hAAAA_5555);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0800_0C00, 32'h0000_3099,
              {32'd0, 32'd0, 32'd0});
        step();
        chk("sb_ir",     ir_o, 32'hAAAA_5555);
        chk("sb_pc",     pc_o, 32'h0000_3028);
        chk("sb_d0",     data_o[31:0], 32'd10);
        chk("sb_bubble", 32'(bubble_cnt_o), 32'd1);
        chk("sb_hold",   32'(hold_cnt_o), 32'd5);

        // Flush with bubble: flush counted, bubble not
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h0000_302C,
              {32'd1, 32'd1, 32'd1});
        step();
        chk("fb_flush",  32'(flush_cnt_o), 32'd2);
        chk("fb_bubble", 32'(bubble_cnt_o), 32'd1);
        chk("fb_pc",     pc_o, 32'h0000_302C);

        // Five bubbles: wide counter reaches 6, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_3030 + 32'(4*i),
                  {32'd1, 32'd1, 32'd1});
            step();
        end
        chk("sat_bubble_w", 32'(bubble_cnt_o), 32'd6);
        chk("sat_bubble_n", 32'(bubble2_cnt),  32'd3);
        chk("sat_pc",       pc_o, 32'h0000_3040);

        // PC+4/PC+8 wrap
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFC,
              {32'd0, 32'd0, 32'd0});
        step();
        chk("wr_pc",  pc_o,  32'hFFFF_FFFC);
        chk("wr_pc4", pc4_o, 32'h0000_0000);
        chk("wr_pc8", pc8_o, 32'h0000_0004);

        // Reset asserted mid-stall wins that edge
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h5555_AAAA, 32'h0000_4000,
              {32'd3, 32'd3, 32'd3});
        step();
        chk("rs_pc",     pc_o, 32'h0000_3000);
        chk("rs_valid",  32'(valid_o), 32'd0);
        chk("rs_hold",   32'(hold_cnt_o), 32'd0);
        chk("rs_flush",  32'(flush_cnt_o), 32'd0);
        chk("rs_bubble", 32'(bubble_cnt_o), 32'd0);

        // First post-reset edge is a normal load
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h2402_00FF, 32'h0000_3040,
              {32'd8, 32'd8, 32'd8});
        step();
        chk("pr_ir",    ir_o, 32'h2402_00FF);
        chk("pr_pc",    pc_o, 32'h0000_3040);
        chk("pr_valid", 32'(valid_o), 32'd1);
        chk("pr_d1",    data_o[63:32], 32'd8);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
